// File: rtl/cta_exit_arbiter.sv
// rtl/cta_exit_arbiter.sv - round-robin arbiter turning warp EXITs into CTA retire requests
`timescale 1ns/1ps
module cta_exit_arbiter #(
    parameter int NUM_WARP     = 8,
    parameter int NUM_WARP_LOG = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall_i,
    input  logic                    exitValid_i,
    input  logic [NUM_WARP_LOG-1:0] exitWarpId_i,
    input  logic                    ctaRun_i,
    input  logic [NUM_WARP-1:0]     ctaRunMask_i,
    input  logic                    kernelDone_i,
    output logic                    ctaExit_o,
    output logic [NUM_WARP_LOG-1:0] exitWarp_o,
    output logic [NUM_WARP-1:0]     pending_o,
    output logic                    busy_o,
    output logic                    drop_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [NUM_WARP-1:0]     pending_q, pending_d;
    logic [NUM_WARP_LOG-1:0] rr_ptr_q, rr_ptr_d;
    logic [NUM_WARP_LOG-1:0] exit_warp_q, exit_warp_d;
    logic                    drop_q, drop_d;

    logic                    capture_ok;
    logic [NUM_WARP-1:0]     set_mask, clr_mask;
    logic                    pick_found;
    logic [NUM_WARP_LOG-1:0] pick_idx, scan_idx;
    int                      scan_pos;

    // Captures bypass the stall; a kernel finishing this cycle turns a capture into a drop.
    assign capture_ok = exitValid_i && ctaRunMask_i[exitWarpId_i]
                        && (state_q != ST_DONE) && !kernelDone_i;
    assign set_mask   = capture_ok ? (NUM_WARP'(1) << exitWarpId_i) : '0;

    // First pending warp at or above rr_ptr_q, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_pos   = 0;
        scan_idx   = '0;
        for (int i = 0; i < NUM_WARP; i++) begin
            scan_pos = int'(rr_ptr_q) + i;
            if (scan_pos >= NUM_WARP) begin
                scan_pos = scan_pos - NUM_WARP;
            end
            scan_idx = NUM_WARP_LOG'(scan_pos);
            if (!pick_found && pending_q[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        exit_warp_d = exit_warp_q;
        clr_mask    = '0;
        if (!stall_i) begin
            if (kernelDone_i) begin
                state_d  = ST_DONE;
                clr_mask = '1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (pick_found) begin
                            exit_warp_d = pick_idx;
                            state_d     = ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        if (ctaRun_i) begin
                            clr_mask = NUM_WARP'(1) << exit_warp_q;
                            rr_ptr_d = (exit_warp_q == NUM_WARP_LOG'(NUM_WARP - 1))
                                       ? '0 : exit_warp_q + NUM_WARP_LOG'(1);
                            state_d  = ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (ctaRun_i) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                        state_d = ST_DONE;
                    end
                endcase
            end
        end
        // A re-exit of the warp being retired survives its own clear.
        pending_d = (pending_q & ~clr_mask) | set_mask;
        drop_d    = exitValid_i && !capture_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            rr_ptr_q    <= '0;
            exit_warp_q <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            exit_warp_q <= exit_warp_d;
            drop_q      <= drop_d;
        end
    end

    assign ctaExit_o  = (state_q == ST_ISSUE);
    assign busy_o     = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign exitWarp_o = exit_warp_q;
    assign pending_o  = pending_q;
    assign drop_o     = drop_q;

endmodule
